aludec_bist: RTL and testbench



---
 rtl/aludec_bist.sv | 198 +++++++++++++++++++
 tb/tb_aludec_bist.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aludec_bist.sv
// aludec_bist -- built-in self-test sequencer for the ALU decoder.
//
// Walks all 128 {ALUOp, funct3, op_5, funct7_5} combinations into an
// external combinational aludecoder. Each vector is held for SETTLE_CYCLES
// cycles and then captured. Every capture on a care vector is folded into a
// 7-bit shift-XOR signature. When the run finishes, pass reports whether
// the signature equals GOLDEN_SIG.
//
// Optional feature macro: ALUDEC_BIST_CHECK_EN
//   When defined, a reference model of the decoder is added for care vectors.
//   Each mismatch on a care vector increments err_count, which saturates at
//   255. The err_count port exists only in this build.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   single-cycle run request (honoured in IDLE or DONE)
//   ALUOp       out  [1:0] decoder stimulus (vec_index[6:5])
//   funct3      out  [2:0] decoder stimulus (vec_index[4:2])
//   op_5        out  decoder stimulus (vec_index[1])
//   funct7_5    out  decoder stimulus (vec_index[0])
//   ALUControl  in   [2:0] decoder response
//   busy        out  run in progress
//   done        out  run complete, held until next start or reset
//   pass        out  signature (and error count) good; 0 unless done
//   signature   out  [6:0] running/final signature
//   vec_index   out  [6:0] current vector number
//   err_count   out  [7:0] model mismatches (ALUDEC_BIST_CHECK_EN only)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start after reset
// APPLY   | stimulus driven, decoder settling for SETTLE_CYCLES cycles
// CAPTURE | one cycle: sample ALUControl, fold signature, advance index
// DONE    | result held; start launches a fresh run

module aludec_bist #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [6:0]  GOLDEN_SIG    = 7'h00
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic [1:0] ALUOp,
   output logic [2:0] funct3,
   output logic       op_5,
   output logic       funct7_5,
   input  logic [2:0] ALUControl,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] signature,
   output logic [6:0] vec_index
`ifdef ALUDEC_BIST_CHECK_EN
   ,
   output logic [7:0] err_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_APPLY   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Settle timer counts down from SETTLE_CYCLES-1; terminal count 0 ends APPLY.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic [6:0] idx, idx_nxt;
   logic [6:0] sig, sig_nxt;
   logic [6:0] sig_fold;
   logic [6:0] sig_upd;
   logic       care;

   // Care vectors: ALUOp 00/01, or ALUOp 10 with funct3 in {000,010,110,111}.
   always_comb begin
      care = 1'b0;
      if (!idx[6]) begin
         care = 1'b1;
      end else if (!idx[5]) begin
         care = (idx[4:2] == 3'b000) || (idx[4:2] == 3'b010) ||
                (idx[4:2] == 3'b110) || (idx[4:2] == 3'b111);
      end
   end

   assign sig_fold = sig ^ {4'b0000, ALUControl};
   assign sig_upd  = {sig_fold[5:0], sig_fold[6] ^ sig_fold[5]};

`ifdef ALUDEC_BIST_CHECK_EN
   logic [7:0] err, err_nxt;
   logic [2:0] model_ctrl;

   always_comb begin
      model_ctrl = 3'b000;
      unique case (idx[6:5])
         2'b00: model_ctrl = 3'b000;
         2'b01: model_ctrl = 3'b001;
         default: begin
            case (idx[4:2])
               3'b000:  model_ctrl = (idx[1:0] == 2'b11) ? 3'b001 : 3'b000;
               3'b010:  model_ctrl = 3'b101;
               3'b110:  model_ctrl = 3'b011;
               3'b111:  model_ctrl = 3'b010;
               default: model_ctrl = 3'b000;
            endcase
         end
      endcase
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         settle_cnt <= 4'd0;
         idx        <= 7'd0;
         sig        <= 7'd0;
`ifdef ALUDEC_BIST_CHECK_EN
         err        <= 8'd0;
`endif
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         idx        <= idx_nxt;
         sig        <= sig_nxt;
`ifdef ALUDEC_BIST_CHECK_EN
         err        <= err_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_cnt;
      idx_nxt    = idx;
      sig_nxt    = sig;
`ifdef ALUDEC_BIST_CHECK_EN
      err_nxt    = err;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt  = S_APPLY;
               settle_nxt = SETTLE_LOAD;
               idx_nxt    = 7'd0;
               sig_nxt    = 7'd0;
`ifdef ALUDEC_BIST_CHECK_EN
               err_nxt    = 8'd0;
`endif
            end
         end
         S_APPLY: begin
            if (settle_cnt == 4'd0) begin
               state_nxt = S_CAPTURE;
            end else begin
               settle_nxt = settle_cnt - 4'd1;
            end
         end
         S_CAPTURE: begin
            if (care) begin
               sig_nxt = sig_upd;
`ifdef ALUDEC_BIST_CHECK_EN
               if ((ALUControl != model_ctrl) && (err != 8'hFF)) begin
                  err_nxt = err + 8'd1;
               end
`endif
            end
            if (idx == 7'd127) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt  = S_APPLY;
               settle_nxt = SETTLE_LOAD;
               idx_nxt    = idx + 7'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign ALUOp     = idx[6:5];
   assign funct3    = idx[4:2];
   assign op_5      = idx[1];
   assign funct7_5  = idx[0];
   assign vec_index = idx;
   assign signature = sig;
   assign busy      = (state == S_APPLY) || (state == S_CAPTURE);
   assign done      = (state == S_DONE);

`ifdef ALUDEC_BIST_CHECK_EN
   assign err_count = err;
   assign pass      = done && (sig == GOLDEN_SIG) && (err == 8'd0);
`else
   assign pass      = done && (sig == GOLDEN_SIG);
`endif

endmodule

// File: tb/tb_aludec_bist.sv
module tb_aludec_bist;

   // Reference decoder behaviour for one vector number; -1 marks don't-care.
   function automatic int ref_ctrl(input int v);
      int op, f3, rf;
      op = v / 32;
      f3 = (v / 4) % 8;
      rf = v % 4;
      if (op == 0) return 0;
      if (op == 1) return 1;
      if (op == 2) begin
         if (f3 == 0) return (rf == 3) ? 1 : 0;
         if (f3 == 2) return 5;
         if (f3 == 6) return 3;
         if (f3 == 7) return 2;
      end
      return -1;
   endfunction

   // Whole-run signature, optionally with one vector's response replaced.
   function automatic int ref_sig(input int fen, input int fidx, input int fval);
      int s, c, r;
      s = 0;
      for (int v = 0; v < 128; v++) begin
         c = ref_ctrl(v);
         if (c >= 0) begin
            r = (fen != 0 && v == fidx) ? fval : c;
            s = s ^ r;
            s = ((s % 64) * 2) + (((s / 64) ^ (s / 32)) % 2);
         end
      end
      return s;
   endfunction

   function automatic int ref_err(input int fen, input int fidx, input int fval);
      if (fen != 0 && ref_ctrl(fidx) >= 0 && ref_ctrl(fidx) != fval) return 1;
      return 0;
   endfunction

   localparam logic [6:0] GOLD = 7'(ref_sig(0, 0, 0));
   localparam int LIMIT = 2000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start1 = 1'b0, start3 = 1'b0;
   logic fault_en = 1'b0;
   logic [6:0] fault_idx = 7'd0;
   logic [2:0] fault_val = 3'd0;

   logic [1:0] aluop1, aluop3;
   logic [2:0] f3_1, f3_3;
   logic       op5_1, op5_3, f75_1, f75_3;
   logic [2:0] ctrl1, ctrl3;
   logic       busy1, busy3, done1, done3, pass1, pass3;
   logic [6:0] sig1, sig3, idx1, idx3;
`ifdef ALUDEC_BIST_CHECK_EN
   logic [7:0] err1, err3;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Correct decoder behaviour; don't-care vectors echo funct3.
   function automatic logic [2:0] dec_model(input logic [6:0] v);
      int c;
      c = ref_ctrl(int'(v));
      return (c >= 0) ? 3'(c) : v[4:2];
   endfunction

   assign ctrl1 = (fault_en && {aluop1, f3_1, op5_1, f75_1} == fault_idx) ?
                  fault_val : dec_model({aluop1, f3_1, op5_1, f75_1});
   assign ctrl3 = dec_model({aluop3, f3_3, op5_3, f75_3});

   aludec_bist #(.SETTLE_CYCLES(1), .GOLDEN_SIG(GOLD)) u1 (
      .clk(clk), .reset_n(reset_n), .start(start1),
      .ALUOp(aluop1), .funct3(f3_1), .op_5(op5_1), .funct7_5(f75_1),
      .ALUControl(ctrl1), .busy(busy1), .done(done1), .pass(pass1),
      .signature(sig1), .vec_index(idx1)
`ifdef ALUDEC_BIST_CHECK_EN
      , .err_count(err1)
`endif
   );

   aludec_bist #(.SETTLE_CYCLES(3), .GOLDEN_SIG(GOLD)) u3 (
      .clk(clk), .reset_n(reset_n), .start(start3),
      .ALUOp(aluop3), .funct3(f3_3), .op_5(op5_3), .funct7_5(f75_3),
      .ALUControl(ctrl3), .busy(busy3), .done(done3), .pass(pass3),
      .signature(sig3), .vec_index(idx3)
`ifdef ALUDEC_BIST_CHECK_EN
      , .err_count(err3)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] cur_idx(input int which);
      return (which == 3) ? idx3 : idx1;
   endfunction
   function automatic logic [6:0] cur_stim(input int which);
      return (which == 3) ? {aluop3, f3_3, op5_3, f75_3} : {aluop1, f3_1, op5_1, f75_1};
   endfunction

   task automatic set_start(input int which, input logic v);
      if (which == 3) start3 = v;
      else start1 = v;
   endtask

   // Pulse start, then count cycles until done; optionally re-pulse start mid-run.
   task automatic run(input int which, input int poke_at, output int lat);
      int per, last_chg, hold_bad, map_bad;
      logic [6:0] prev;
      per = (which == 3) ? 4 : 2;
      last_chg = 0; hold_bad = 0; map_bad = 0; prev = 7'd0;
      @(negedge clk); set_start(which, 1'b1);
      @(posedge clk); #1 set_start(which, 1'b0);
      chk("start_busy", (which == 3) ? busy3 : busy1, 1);
      chk("start_done", (which == 3) ? done3 : done1, 0);
      chk("start_idx", cur_idx(which), 0);
      chk("start_sig", (which == 3) ? sig3 : sig1, 0);
      lat = 0;
      while (!((which == 3) ? done3 : done1) && lat < LIMIT) begin
         @(posedge clk); #1 lat++;
         set_start(which, (lat == poke_at) ? 1'b1 : 1'b0);
         if (cur_idx(which) != prev) begin
            if (lat - last_chg != per) hold_bad++;
            last_chg = lat;
            prev = cur_idx(which);
         end
         if (cur_stim(which) != cur_idx(which)) map_bad++;
      end
      set_start(which, 1'b0);
      chk("run_latency", lat, 128 * per);
      chk("vector_hold", hold_bad, 0);
      chk("stim_mapping", map_bad, 0);
   endtask

   task automatic check_result1(input int exp_sig, input bit exp_pass, input int exp_err);
      chk("done", done1, 1);
      chk("busy_end", busy1, 0);
      chk("pass", pass1, exp_pass);
      chk("signature", sig1, exp_sig);
      chk("vec_index_end", idx1, 127);
`ifdef ALUDEC_BIST_CHECK_EN
      chk("err_count", err1, exp_err);
`else
      if (exp_err < 0) chk("err_arg", exp_err, 0);
`endif
   endtask

   typedef struct {
      bit         fen;
      logic [6:0] fidx;
      logic [2:0] fval;
      bit         exp_pass;
      int         exp_err;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int lat, fi, fv, es, ee, n;
      bit ep;

      tbl[0] = '{1'b0, 7'h00, 3'd0, 1'b1, 0};   // clean decoder
      tbl[1] = '{1'b1, 7'h43, 3'd0, 1'b0, 1};   // care fault, sub R-type
      tbl[2] = '{1'b1, 7'h60, 3'd7, 1'b1, 0};   // don't-care fault, ALUOp 11
      tbl[3] = '{1'b1, 7'h00, 3'd5, 1'b0, 1};   // first vector
      tbl[4] = '{1'b1, 7'h7F, 3'd1, 1'b1, 0};   // last vector, don't-care
      tbl[5] = '{1'b1, 7'h5F, 3'd0, 1'b0, 1};   // last care vector (and)

      #1;
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_pass", pass1, 0);
      chk("rst_sig", sig1, 0);
      chk("rst_idx", idx1, 0);
      chk("rst_stim", cur_stim(1), 0);
`ifdef ALUDEC_BIST_CHECK_EN
      chk("rst_err", err1, 0);
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_start", busy1, 0);

      for (int i = 0; i < 6; i++) begin
         fault_en = tbl[i].fen; fault_idx = tbl[i].fidx; fault_val = tbl[i].fval;
         run(1, 0, lat);
         check_result1(ref_sig(tbl[i].fen, tbl[i].fidx, tbl[i].fval), tbl[i].exp_pass,
                       tbl[i].exp_err);
      end

      for (int i = 0; i < 4; i++) begin
         fi = $urandom_range(0, 127);
         fv = $urandom_range(0, 7);
         fault_en = 1'b1; fault_idx = 7'(fi); fault_val = 3'(fv);
         es = ref_sig(1, fi, fv);
         ee = ref_err(1, fi, fv);
`ifdef ALUDEC_BIST_CHECK_EN
         ep = (es == int'(GOLD)) && (ee == 0);
`else
         ep = (es == int'(GOLD));
`endif
         run(1, $urandom_range(1, 250), lat);
         check_result1(es, ep, ee);
      end
      fault_en = 1'b0;

      // Back-to-back restart from DONE reproduces the clean signature.
      run(1, 0, lat);
      check_result1(int'(GOLD), 1'b1, 0);

      // Reset in the middle of a run.
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      n = 0;
      while (idx1 != 7'h20 && n < LIMIT) begin
         @(posedge clk); #1 n++;
      end
      chk("reach_idx20", idx1, 7'h20);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_done", done1, 0);
      chk("mid_rst_pass", pass1, 0);
      chk("mid_rst_sig", sig1, 0);
      chk("mid_rst_idx", idx1, 0);
      chk("mid_rst_stim", cur_stim(1), 0);
`ifdef ALUDEC_BIST_CHECK_EN
      chk("mid_rst_err", err1, 0);
`endif
      @(negedge clk); reset_n = 1'b1;
      run(1, 0, lat);
      check_result1(int'(GOLD), 1'b1, 0);

      // Longer settle time on the second instance.
      run(3, 0, lat);
      chk("s3_done", done3, 1);
      chk("s3_pass", pass3, 1);
      chk("s3_sig", sig3, GOLD);
      chk("s3_idx", idx3, 127);

      // Start in DONE: done drops on the next edge.
      @(negedge clk); start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      chk("restart_done_low", done1, 0);
      chk("restart_pass_low", pass1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
